// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity mode, default bit timing.
// Used by both the transmitter and the receiver.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state encoding.
package uart_pkg;

   // Default number of clock cycles per serial bit
   localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

   // Parity mode: 1 selects even parity (parity bit = XOR of the data bits)
   localparam bit UART_PARITY_EVEN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_STOP   = 3'd6
   } uart_state_e;

   // Parity bit for one byte in the configured parity mode
   function automatic logic uart_parity(input logic [7:0] data);
      return (^data) ^ ~UART_PARITY_EVEN;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: Bit_Done pulses on the last cycle of every
// Clks_Per_Bit-cycle period. Restart holds the count at zero so the
// first period after Restart drops is a full bit.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int Clks_Per_Bit = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Restart,
   output logic Bit_Done
);

   localparam logic [15:0] LAST_COUNT = 16'(Clks_Per_Bit - 1);

   logic [15:0] count;

   // Free-running cycle count within the current bit, reloaded at each boundary
   always_ff @(posedge Clk) begin
      if (Reset || Restart) begin
         count <= '0;
      end else if (count == LAST_COUNT) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

   assign Bit_Done = (count == LAST_COUNT) && !Restart;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from an upstream FIFO (one-cycle read
// latency) and sends them as start / 8 data bits LSB first / [parity] /
// stop bits. Back-to-back frames are separated by a fixed 3-cycle gap
// (IDLE, FETCH, LOAD).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int Clks_Per_Bit = UART_DEFAULT_CLKS_PER_BIT,
   parameter int Stop_Bits    = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] Fifo_Data,
   input  logic       Fifo_Empty,
   output logic       Fifo_Read,
   output logic       Tx,
   output logic       Busy
);

   localparam logic [2:0] LAST_STOP = 3'(Stop_Bits - 1);

   uart_state_e state;
   uart_state_e next_state;
   logic [7:0]  shift_q;
   logic [2:0]  bit_cnt;
   logic        bit_done;
   logic        restart;
`ifdef UART_TX_PARITY_EN
   logic        parity_q;
`endif

   uart_baud_counter #(
      .Clks_Per_Bit (Clks_Per_Bit)
   ) u_baud (
      .Clk      (Clk),
      .Reset    (Reset),
      .Restart  (restart),
      .Bit_Done (bit_done)
   );

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and line/handshake outputs
   always_comb begin
      next_state = state;
      Fifo_Read  = 1'b0;
      Tx         = 1'b1;
      Busy       = (state != ST_IDLE);
      restart    = 1'b0;
      case (state)
         ST_IDLE: begin
            restart = 1'b1;
            if (!Fifo_Empty && !Reset) begin
               Fifo_Read  = 1'b1;
               next_state = ST_FETCH;
            end
         end
         ST_FETCH: begin
            restart    = 1'b1;
            next_state = ST_LOAD;
         end
         ST_LOAD: begin
            restart    = 1'b1;
            next_state = ST_START;
         end
         ST_START: begin
            Tx = 1'b0;
            if (bit_done) begin
               next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            Tx = shift_q[0];
            if (bit_done && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               next_state = ST_PARITY;
`else
               next_state = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            Tx = parity_q;
            if (bit_done) begin
               next_state = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_done && (bit_cnt == LAST_STOP)) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Shift register and bit counter; the counter wraps 7->0 leaving DATA,
   // so it is already cleared for counting stop bits
   always_ff @(posedge Clk) begin
      if (Reset) begin
         shift_q <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               shift_q <= Fifo_Data;
               bit_cnt <= '0;
            end
            ST_DATA: begin
               if (bit_done) begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            default: begin
               shift_q <= shift_q;
               bit_cnt <= bit_cnt;
            end
         endcase
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity of the byte is latched with it, since the shifter consumes the data
   always_ff @(posedge Clk) begin
      if (Reset) begin
         parity_q <= 1'b0;
      end else if (state == ST_LOAD) begin
         parity_q <= uart_parity(Fifo_Data);
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: one instance with 1 stop bit and one with
// 2 stop bits, both at 4 clocks per bit, fed from a small FIFO model with
// one-cycle read latency. Honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME1 = 10 + PAR_BITS;
   localparam int FRAME2 = FRAME1 + 1;
   localparam int F1C    = FRAME1 * CPB;
   localparam int F2C    = FRAME2 * CPB;

   typedef struct {
      logic [7:0] data;
      logic       exp_par;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] Fifo_Data;
   logic       Fifo_Empty;
   logic       Fifo_Read, Tx, Busy;
   logic       Fifo_Read2, Tx2, Busy2;

   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr  = 8'd0;
   logic [7:0] rd_ptr  = 8'd0;
   logic [7:0] rd_data = 8'd0;

   int checks = 0;
   int errors = 0;
   vec_t vecs [8];

   uart_tx_serializer #(.Clks_Per_Bit(CPB), .Stop_Bits(1)) dut (
      .Clk(Clk), .Reset(Reset), .Fifo_Data(Fifo_Data), .Fifo_Empty(Fifo_Empty),
      .Fifo_Read(Fifo_Read), .Tx(Tx), .Busy(Busy));

   uart_tx_serializer #(.Clks_Per_Bit(CPB), .Stop_Bits(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .Fifo_Data(Fifo_Data), .Fifo_Empty(Fifo_Empty),
      .Fifo_Read(Fifo_Read2), .Tx(Tx2), .Busy(Busy2));

   always #5 Clk = ~Clk;

   // FIFO model: only the first instance pops; data appears one cycle after the read
   assign Fifo_Empty = (wr_ptr == rd_ptr);
   assign Fifo_Data  = rd_data;
   always @(posedge Clk) begin
      if (Fifo_Read) begin
         rd_data <= mem[rd_ptr];
         rd_ptr  <= rd_ptr + 8'd1;
      end
   end

   task automatic push(input logic [7:0] d);
      mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic check(input string name, input int cyc, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   // Expected line level for bit slot idx of a frame
   function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (idx == 9 && PAR_BITS == 1) return p;
      return 1'b1;
   endfunction

   task automatic run_frame(input logic [7:0] d, input logic p);
      int k;
      push(d);
      #1;
      check("read_pulse", 0, Fifo_Read, 1'b1);
      check("read_pulse2", 0, Fifo_Read2, 1'b1);
      check("busy_idle", 0, Busy, 1'b0);
      for (int c = 1; c <= 3 + F2C; c++) begin
         @(negedge Clk);
         k = c - 3;
         check("read_once", c, Fifo_Read, 1'b0);
         check("tx", c, Tx, (c < 3) ? 1'b1 : ((k < F1C) ? exp_bit(d, p, k / CPB) : 1'b1));
         check("busy", c, Busy, (k < F1C) ? 1'b1 : 1'b0);
         check("tx_2stop", c, Tx2, (c < 3) ? 1'b1 : ((k < F2C) ? exp_bit(d, p, k / CPB) : 1'b1));
         check("busy_2stop", c, Busy2, (k < F2C) ? 1'b1 : 1'b0);
      end
   endtask

   initial begin
      int reads;
      logic etx, ebusy, erd;
      logic [7:0] d;

      vecs[0] = '{8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b0};
      vecs[3] = '{8'h07, 1'b1};
      vecs[4] = '{8'h03, 1'b0};
      vecs[5] = '{8'h80, 1'b1};
      vecs[6] = '{8'h5A, 1'b0};
      vecs[7] = '{8'h01, 1'b1};

      // Reset state
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("rst_tx", 0, Tx, 1'b1);
      check("rst_busy", 0, Busy, 1'b0);
      check("rst_read", 0, Fifo_Read, 1'b0);
      check("rst_tx2", 0, Tx2, 1'b1);
      check("rst_busy2", 0, Busy2, 1'b0);
      Reset = 1'b0;
      @(negedge Clk);

      // Empty FIFO: line stays idle
      for (int c = 0; c < 100; c++) begin
         @(negedge Clk);
         check("idle_read", c, Fifo_Read, 1'b0);
         check("idle_tx", c, Tx, 1'b1);
         check("idle_busy", c, Busy, 1'b0);
      end

      // Single frames from the vector table
      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].data, vecs[i].exp_par);
         repeat (8) @(negedge Clk);
      end

      // Back-to-back 00 then FF: fixed 3-cycle gap at Tx=1
      reads = 0;
      push(8'h00);
      push(8'hFF);
      #1;
      for (int c = 0; c <= 6 + 2 * F1C; c++) begin
         if (c > 0) @(negedge Clk);
         erd   = (c == 0 || c == 3 + F1C);
         ebusy = !(c == 0 || c == 3 + F1C || c == 6 + 2 * F1C);
         if (c < 3) etx = 1'b1;
         else if (c < 3 + F1C) etx = exp_bit(8'h00, 1'b0, (c - 3) / CPB);
         else if (c < 6 + F1C) etx = 1'b1;
         else if (c < 6 + 2 * F1C) etx = exp_bit(8'hFF, 1'b0, (c - 6 - F1C) / CPB);
         else etx = 1'b1;
         if (Fifo_Read) reads++;
         check("b2b_read", c, Fifo_Read, erd);
         check("b2b_tx", c, Tx, etx);
         check("b2b_busy", c, Busy, ebusy);
      end
      checks++;
      if (reads != 2) begin
         errors++;
         $display("FAIL b2b_read_count actual=%0d required=2", reads);
      end
      repeat (30) @(negedge Clk);

      // Reset during data bit 3 of 3C
      d = 8'h3C;
      push(d);
      #1;
      repeat (3 + 3 * CPB + 2) @(negedge Clk);
      check("pre_rst_bit2", 0, Tx, d[2]);
      repeat (CPB) @(negedge Clk);
      check("pre_rst_bit3", 0, Tx, d[3]);
      check("pre_rst_busy", 0, Busy, 1'b1);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort_tx", 0, Tx, 1'b1);
      check("abort_busy", 0, Busy, 1'b0);
      check("abort_read", 0, Fifo_Read, 1'b0);
      check("abort_busy2", 0, Busy2, 1'b0);
      Reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         check("post_rst_read", c, Fifo_Read, 1'b0);
         check("post_rst_tx", c, Tx, 1'b1);
         check("post_rst_busy", c, Busy, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter Clks_Per_Bit, default 16: Clk cycles per serial bit, legal range 2..65535.
REQ-002 Parameter Stop_Bits, default 1: number of stop bits, legal values 1 or 2.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 Fifo_Data  input  8  byte from the upstream FIFO read port.
REQ-006 Fifo_Empty  input  1  high when the upstream FIFO holds no bytes.
REQ-007 Fifo_Read  output  1  one-cycle pulse that pops one byte from the upstream FIFO.
REQ-008 Tx  output  1  serial line; idle level 1; LSB first.
REQ-009 Busy  output  1  high from the Fifo_Read pulse until the last stop bit completes.

Function
REQ-010 State machine SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-011 IDLE: if Fifo_Empty==0 then assert Fifo_Read for exactly one cycle and go to FETCH; otherwise stay in IDLE.
REQ-012 FETCH: wait one cycle (FIFO read latency), then go to LOAD.
REQ-013 LOAD: capture Fifo_Data into an 8-bit shift register, clear the bit counter, then go to START.
REQ-014 START: Tx=0 for Clks_Per_Bit cycles, then go to DATA.
REQ-015 DATA: Tx=shift[0]; after each Clks_Per_Bit cycles shift right and increment the 3-bit counter; after bit 7 go to PARITY if enabled, else STOP.
REQ-016 STOP: Tx=1 for Stop_Bits*Clks_Per_Bit cycles, then go to IDLE.
REQ-017 Each serial bit SHALL last exactly Clks_Per_Bit cycles; the baud counter reloads at every bit boundary.
REQ-018 Fifo_Read SHALL never be asserted while Fifo_Empty==1 or outside IDLE.
REQ-019 Back-to-back: if Fifo_Empty==0 on the cycle STOP ends, the path is IDLE (1 cycle, Fifo_Read) -> FETCH -> LOAD, giving a fixed 3-cycle idle gap between frames.
REQ-020 Latency: the first falling edge of Tx SHALL occur 3 cycles after the IDLE cycle that sees Fifo_Empty==0.
REQ-021 Fifo_Empty rising mid-frame SHALL NOT affect the frame in progress.
REQ-022 Busy SHALL be 0 only in IDLE.

Reset
REQ-023 Reset SHALL force state IDLE, Tx=1, Fifo_Read=0, Busy=0, and clear the shift register, bit counter and baud counter.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; the partial byte is discarded and not re-fetched.
REQ-025 Reset SHALL have priority over all other inputs.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and drive Tx to the even parity of the byte (XOR of its 8 bits) for Clks_Per_Bit cycles.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, and DATA goes directly to STOP.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state encoding constants, the parity-mode constant and the default Clks_Per_Bit; the receiver reuses this package.
REQ-029 The baud timing SHALL be a sub-module uart_baud_counter: inputs Clk, Reset, Restart; output Bit_Done, a one-cycle pulse every Clks_Per_Bit cycles.

Verification
REQ-030 Reset, Clks_Per_Bit=4, Fifo_Data=8'hA5, Fifo_Empty falls -> one Fifo_Read pulse; Tx=0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; Busy then clears.
REQ-031 Two bytes 8'h00 and 8'hFF queued -> two Fifo_Read pulses; frames separated by exactly 3 idle cycles at Tx=1.
REQ-032 Fifo_Empty held at 1 for 100 cycles -> Fifo_Read stays 0, Tx stays 1, Busy stays 0.
REQ-033 Reset asserted during data bit 3 of 8'h3C -> Tx=1 and Busy=0 on the next cycle; no further Fifo_Read while Fifo_Empty==1.
REQ-034 UART_TX_PARITY_EN defined, byte 8'h07 -> parity bit 1; byte 8'h03 -> parity bit 0; each frame is 11 bits long.
REQ-035 Stop_Bits=2, Clks_Per_Bit=4 -> Tx held at 1 for 8 cycles before the next start bit.
